i2s_transceiver: RTL and testbench

//  Parametrised I2S master for the Pmod I2S2 ADC/DAC pair. Generates MCLK, LRCK and SCLK from clk100.

---
 rtl/i2s_transceiver.sv | 203 ++++++++++++++++++++
 tb/tb_i2s_transceiver.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_transceiver.sv
// I2S master for the Pmod I2S2: derives MCLK/SCLK/LRCK from clk100, serialises the
// DAC stereo pair and deserialises the ADC stereo pair with valid/ready handshakes.
module i2s_transceiver #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int SCLK_DIV = 8,
  parameter int MCLK_DIV = 2,
  parameter int JUSTIFY  = 0
) (
  input  logic              clk100,
  input  logic              rst,
  output logic              mclk,
  output logic              lrck,
  output logic              sclk,
  output logic              dac_sdata,
  input  logic              adc_sdata,
  input  logic [DATA_W-1:0] tx_l,
  input  logic [DATA_W-1:0] tx_r,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_l,
  output logic [DATA_W-1:0] rx_r,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic              clr_flags,
  output logic              tx_underrun,
  output logic              rx_overrun
);

  localparam int P_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int K_W = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam int M_W = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
  localparam int OFF = (JUSTIFY != 0) ? 0 : 1;

  localparam logic [P_W-1:0] P_LAST = P_W'(SCLK_DIV - 1);
  localparam logic [P_W-1:0] P_RISE = P_W'(SCLK_DIV / 2);
  localparam logic [K_W-1:0] K_LAST = K_W'(SLOT_W - 1);
  localparam logic [M_W-1:0] M_LAST = M_W'(MCLK_DIV - 1);
  localparam logic [M_W-1:0] M_HALF = M_W'(MCLK_DIV / 2);

  // The frame counter is kept split as phase / bit-in-slot / slot so no division is needed.
  logic [P_W-1:0] p_q, p_d;
  logic [K_W-1:0] k_q, k_d;
  logic           lr_q, lr_d;
  logic [M_W-1:0] m_q, m_d;
  logic           frame_end;

  logic mclk_q, lrck_q, sclk_q, dac_q, dac_d;

  logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [DATA_W-1:0] frm_l_q, frm_l_d, frm_r_q, frm_r_d;
  logic              tx_ready_q, tx_ready_d, tx_hs, urun_ev;
  logic              urun_q, urun_d;

  logic [DATA_W-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic [DATA_W-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d;
  logic              rx_valid_q, rx_valid_d, sample, orun_ev;
  logic              orun_q, orun_d;

  function automatic logic in_data(input logic [K_W-1:0] k);
    int j;
    j = int'(k) - OFF;
    return (j >= 0) && (j < DATA_W);
  endfunction

  function automatic logic slot_bit(input logic [K_W-1:0] k, input logic [DATA_W-1:0] w);
    int j;
    logic [DATA_W-1:0] sh;
    j = int'(k) - OFF;
    slot_bit = 1'b0;
    if ((j >= 0) && (j < DATA_W)) begin
      sh = w << j;
      slot_bit = sh[DATA_W-1];
    end
  endfunction

  always_comb begin
    p_d       = p_q + P_W'(1);
    k_d       = k_q;
    lr_d      = lr_q;
    frame_end = (p_q == P_LAST) && (k_q == K_LAST) && lr_q;
    if (p_q == P_LAST) begin
      p_d = '0;
      if (k_q == K_LAST) begin
        k_d  = '0;
        lr_d = ~lr_q;
      end else begin
        k_d = k_q + K_W'(1);
      end
    end
    m_d = (m_q == M_LAST) ? '0 : m_q + M_W'(1);
  end

  // TX: holding register feeds the frame register once per frame; empty holding repeats the last pair.
  always_comb begin
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    frm_l_d    = frm_l_q;
    frm_r_d    = frm_r_q;
    tx_ready_d = tx_ready_q;
    urun_ev    = 1'b0;
    tx_hs      = tx_valid && tx_ready_q;
    if (frame_end) begin
      if (!tx_ready_q) begin
        frm_l_d = hold_l_q;
        frm_r_d = hold_r_q;
      end else begin
        urun_ev = 1'b1;
      end
      tx_ready_d = 1'b1;
    end
    if (tx_hs) begin
      hold_l_d   = tx_l;
      hold_r_d   = tx_r;
      tx_ready_d = 1'b0;
    end
    urun_d = (urun_q & ~clr_flags) | urun_ev;
    dac_d  = dac_q;
    if (p_d == '0) dac_d = slot_bit(k_d, lr_d ? frm_r_d : frm_l_d);
  end

  // RX: the shifted-in value (including a bit sampled this cycle) is published at frame wrap.
  always_comb begin
    sh_l_d     = sh_l_q;
    sh_r_d     = sh_r_q;
    rx_l_d     = rx_l_q;
    rx_r_d     = rx_r_q;
    rx_valid_d = rx_valid_q;
    orun_ev    = 1'b0;
    sample     = (p_q == P_RISE) && in_data(k_q);
    if (sample) begin
      if (lr_q) sh_r_d = (sh_r_q << 1) | DATA_W'(adc_sdata);
      else      sh_l_d = (sh_l_q << 1) | DATA_W'(adc_sdata);
    end
    if (frame_end) begin
      rx_l_d     = sh_l_d;
      rx_r_d     = sh_r_d;
      rx_valid_d = 1'b1;
      orun_ev    = rx_valid_q && !rx_ready;
    end else if (rx_ready) begin
      rx_valid_d = 1'b0;
    end
    orun_d = (orun_q & ~clr_flags) | orun_ev;
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      p_q        <= '0;
      k_q        <= '0;
      lr_q       <= 1'b0;
      m_q        <= '0;
      mclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      sclk_q     <= 1'b0;
      dac_q      <= 1'b0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      frm_l_q    <= '0;
      frm_r_q    <= '0;
      tx_ready_q <= 1'b1;
      urun_q     <= 1'b0;
      sh_l_q     <= '0;
      sh_r_q     <= '0;
      rx_l_q     <= '0;
      rx_r_q     <= '0;
      rx_valid_q <= 1'b0;
      orun_q     <= 1'b0;
    end else begin
      p_q        <= p_d;
      k_q        <= k_d;
      lr_q       <= lr_d;
      m_q        <= m_d;
      mclk_q     <= (m_d >= M_HALF);
      lrck_q     <= lr_d;
      sclk_q     <= (p_d >= P_RISE);
      dac_q      <= dac_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      frm_l_q    <= frm_l_d;
      frm_r_q    <= frm_r_d;
      tx_ready_q <= tx_ready_d;
      urun_q     <= urun_d;
      sh_l_q     <= sh_l_d;
      sh_r_q     <= sh_r_d;
      rx_l_q     <= rx_l_d;
      rx_r_q     <= rx_r_d;
      rx_valid_q <= rx_valid_d;
      orun_q     <= orun_d;
    end
  end

  assign mclk        = mclk_q;
  assign lrck        = lrck_q;
  assign sclk        = sclk_q;
  assign dac_sdata   = dac_q;
  assign tx_ready    = tx_ready_q;
  assign tx_underrun = urun_q;
  assign rx_l        = rx_l_q;
  assign rx_r        = rx_r_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = orun_q;

endmodule

// File: tb/tb_i2s_transceiver.sv
// Bench for i2s_transceiver: a frame-level reference model checks every output each cycle,
// plus vector tables and directed sequences for loopback, ADC framing, flags and reset.
module tb_i2s_transceiver;
  localparam int FRAME = 512;
  localparam int LAST  = FRAME - 1;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [23:0] el;
    logic [23:0] er;
  } vec_t;

  logic clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  logic rst = 1'b1, tx_valid = 1'b0, rx_ready = 1'b1, clr_flags = 1'b0;
  logic [23:0] tx_l = '0, tx_r = '0;
  logic adc_drv = 1'b0, adc1_drv = 1'b0, lb = 1'b0;
  logic adc0;

  logic mclk, lrck, sclk, dac_sdata, tx_ready, rx_valid, tx_underrun, rx_overrun;
  logic [23:0] rx_l, rx_r;
  logic mclk1, lrck1, sclk1, dac1, tx_ready1, rx_valid1, tx_underrun1, rx_overrun1;
  logic [23:0] rx_l1, rx_r1;

  assign adc0 = lb ? dac_sdata : adc_drv;

  i2s_transceiver #(.JUSTIFY(0)) dut (
    .clk100(clk100), .rst(rst), .mclk(mclk), .lrck(lrck), .sclk(sclk),
    .dac_sdata(dac_sdata), .adc_sdata(adc0), .tx_l(tx_l), .tx_r(tx_r),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_l(rx_l), .rx_r(rx_r),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .clr_flags(clr_flags),
    .tx_underrun(tx_underrun), .rx_overrun(rx_overrun));

  i2s_transceiver #(.JUSTIFY(1)) dut_lj (
    .clk100(clk100), .rst(rst), .mclk(mclk1), .lrck(lrck1), .sclk(sclk1),
    .dac_sdata(dac1), .adc_sdata(adc1_drv), .tx_l(24'h0), .tx_r(24'h0),
    .tx_valid(1'b0), .tx_ready(tx_ready1), .rx_l(rx_l1), .rx_r(rx_r1),
    .rx_valid(rx_valid1), .rx_ready(1'b1), .clr_flags(1'b0),
    .tx_underrun(tx_underrun1), .rx_overrun(rx_overrun1));

  // Reference model state
  int mc = 0;
  bit hold_full = 0, m_rxv = 0, m_ur = 0, m_or = 0, m_rxv1 = 0, m_ur1 = 0, hs_seen = 0;
  logic [23:0] hold_l = '0, hold_r = '0, fr_l = '0, fr_r = '0;
  logic [23:0] m_rx_l = '0, m_rx_r = '0, adc_l = '0, adc_r = '0;
  int n_chk = 0, n_fail = 0;

  vec_t lbv[4];
  vec_t adv[3];

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t cnt=%0d: got %h expected %h", nm, $time, mc, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at t=%0t", nm, $time);
  endtask

  // Serial bit carried at frame position c for a word pair; off = 1 for I2S, 0 for left-justified.
  function automatic logic exp_bit(input logic [23:0] wl, input logic [23:0] wr, input int c,
                                   input int off);
    int j;
    logic [23:0] w, t;
    j = ((c / 8) % 32) - off;
    w = (c >= 256) ? wr : wl;
    if (j < 0 || j >= 24) return 1'b0;
    t = w >> (23 - j);
    return t[0];
  endfunction

  function automatic bit in_slot(input int c, input int off);
    int j;
    j = ((c / 8) % 32) - off;
    return (j >= 0) && (j < 24);
  endfunction

  task automatic drive_adc();
    adc_drv  = in_slot(mc, 1) ? exp_bit(adc_l, adc_r, mc, 1) : 1'($urandom);
    adc1_drv = in_slot(mc, 0) ? exp_bit(adc_l, adc_r, mc, 0) : 1'($urandom);
  endtask

  task automatic set_adc(input logic [23:0] l, input logic [23:0] r);
    adc_l = l;
    adc_r = r;
    drive_adc();
  endtask

  task automatic tick();
    bit r, tv, rr, clr, lbm, wrap, hs, ur_ev, or_ev;
    logic [23:0] tl, tr, nl, nr;
    r = rst; tv = tx_valid; rr = rx_ready; clr = clr_flags; lbm = lb;
    tl = tx_l; tr = tx_r;
    hs_seen = 0;
    @(posedge clk100);
    if (r) begin
      mc = 0; hold_full = 0; hold_l = '0; hold_r = '0; fr_l = '0; fr_r = '0;
      m_rx_l = '0; m_rx_r = '0; m_rxv = 0; m_ur = 0; m_or = 0; m_rxv1 = 0; m_ur1 = 0;
    end else begin
      wrap = (mc == LAST);
      hs = tv && !hold_full;
      ur_ev = 0; or_ev = 0;
      nl = lbm ? fr_l : adc_l;
      nr = lbm ? fr_r : adc_r;
      if (wrap) begin
        if (hold_full) begin fr_l = hold_l; fr_r = hold_r; end
        else ur_ev = 1;
        hold_full = 0;
      end
      if (hs) begin hold_l = tl; hold_r = tr; hold_full = 1; hs_seen = 1; end
      if (wrap) begin
        or_ev = m_rxv && !rr;
        m_rxv = 1; m_rx_l = nl; m_rx_r = nr;
      end else if (rr) begin
        m_rxv = 0;
      end
      m_ur = (m_ur && !clr) || ur_ev;
      m_or = (m_or && !clr) || or_ev;
      m_rxv1 = wrap;
      m_ur1 = m_ur1 || wrap;
      mc = wrap ? 0 : mc + 1;
    end
    #1;
    drive_adc();
    chk("sclk", sclk, (mc % 8) >= 4);
    chk("lrck", lrck, mc >= 256);
    chk("mclk", mclk, (mc % 2) >= 1);
    chk("dac_sdata", dac_sdata, exp_bit(fr_l, fr_r, mc, 1));
    chk("tx_ready", tx_ready, !hold_full);
    chk("rx_valid", rx_valid, m_rxv);
    chk("rx_l", rx_l, m_rx_l);
    chk("rx_r", rx_r, m_rx_r);
    chk("tx_underrun", tx_underrun, m_ur);
    chk("rx_overrun", rx_overrun, m_or);
    chk("lj_clocks", {sclk1, lrck1, mclk1}, {sclk, lrck, mclk});
    chk("lj_tx_idle", {dac1, tx_ready1, tx_underrun1, rx_overrun1}, {1'b0, 1'b1, m_ur1, 1'b0});
    chk("lj_rx_valid", rx_valid1, m_rxv1);
  endtask

  task automatic run_to(input int m);
    int n;
    n = 0;
    while (mc != m && n < 2 * FRAME) begin tick(); n++; end
    if (mc != m) timeout("run_to");
  endtask

  task automatic write_tx(input logic [23:0] l, input logic [23:0] r);
    bit ok;
    ok = 0;
    tx_l = l; tx_r = r; tx_valid = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (hs_seen) begin ok = 1; break; end
    end
    tx_valid = 1'b0;
    if (!ok) timeout("tx_handshake");
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
  endtask

  initial begin
    logic ps, pl;
    lbv[0] = '{24'h400000, 24'h555555, 24'h400000, 24'h555555};
    lbv[1] = '{24'hFFFFFF, 24'h000001, 24'hFFFFFF, 24'h000001};
    lbv[2] = '{24'h800000, 24'h7FFFFF, 24'h800000, 24'h7FFFFF};
    lbv[3] = '{24'hA5A5A5, 24'h5A5A5A, 24'hA5A5A5, 24'h5A5A5A};
    adv[0] = '{24'h800001, 24'h7FFFFF, 24'h800001, 24'h7FFFFF};
    adv[1] = '{24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF};
    adv[2] = '{24'h123456, 24'hFEDCBA, 24'h123456, 24'hFEDCBA};

    // Reset and free-running clocks; lrck may only move when sclk falls.
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      ps = sclk; pl = lrck;
      tick();
      if (lrck !== pl) chk("lrck_on_sclk_fall", {ps, sclk}, 2'b10);
    end

    // Loopback: a pair written in frame N is heard back at the end of frame N+1.
    lb = 1'b1;
    for (int v = 0; v < 4; v++) begin
      run_to(0);
      write_tx(lbv[v].l, lbv[v].r);
      run_to(LAST); tick();
      run_to(LAST); tick();
      chk("loop_rx_l", rx_l, lbv[v].el);
      chk("loop_rx_r", rx_r, lbv[v].er);
      chk("loop_rx_valid", rx_valid, 1'b1);
    end

    // ADC model frames into both the I2S and the left-justified build.
    lb = 1'b0;
    for (int v = 0; v < 3; v++) begin
      run_to(0);
      set_adc(adv[v].l, adv[v].r);
      run_to(LAST); tick();
      chk("adc_i2s_rx_l", rx_l, adv[v].el);
      chk("adc_i2s_rx_r", rx_r, adv[v].er);
      chk("adc_lj_rx_l", rx_l1, adv[v].el);
      chk("adc_lj_rx_r", rx_r1, adv[v].er);
      chk("adc_lj_rx_valid", rx_valid1, 1'b1);
    end

    // Underrun: one write, then the pair repeats; clear races a new event and loses.
    lb = 1'b1;
    run_to(0);
    pulse_clr();
    write_tx(24'h123456, 24'hABCDEF);
    run_to(LAST); tick();
    chk("ur_clear_after_fill", tx_underrun, 1'b0);
    run_to(LAST); tick();
    chk("ur_set", tx_underrun, 1'b1);
    chk("ur_rx_l", rx_l, 24'h123456);
    run_to(LAST); tick();
    chk("ur_repeat_rx_l", rx_l, 24'h123456);
    chk("ur_repeat_rx_r", rx_r, 24'hABCDEF);
    run_to(LAST);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("ur_set_wins", tx_underrun, 1'b1);
    pulse_clr();
    chk("ur_cleared", tx_underrun, 1'b0);

    // Overrun: three frames unconsumed, rx keeps the newest; ready on the wrap avoids it.
    lb = 1'b0;
    run_to(0);
    rx_ready = 1'b0;
    pulse_clr();
    for (int f = 1; f <= 3; f++) begin
      set_adc(24'h111111 * f, ~(24'h111111 * f));
      run_to(LAST); tick();
    end
    chk("or_set", rx_overrun, 1'b1);
    chk("or_latest_l", rx_l, 24'h333333);
    chk("or_latest_r", rx_r, 24'hCCCCCC);
    pulse_clr();
    chk("or_cleared", rx_overrun, 1'b0);
    run_to(LAST);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("or_ready_on_wrap", rx_overrun, 1'b0);
    chk("or_ready_on_wrap_valid", rx_valid, 1'b1);
    rx_ready = 1'b1;

    // Reset in the middle of a frame.
    run_to(200);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_outputs", {sclk, lrck, mclk, dac_sdata, rx_valid, tx_ready}, 6'b000001);
    run_to(LAST);
    chk("rst_no_rx_valid", rx_valid, 1'b0);
    tick();
    chk("rst_first_frame_valid", rx_valid, 1'b1);

    // Random traffic against the model.
    for (int c = 0; c < 8 * FRAME; c++) begin
      if (mc == 0) begin
        lb = 1'($urandom);
        set_adc(24'($urandom), 24'($urandom));
      end
      tx_valid  = ($urandom % 128) == 0;
      tx_l      = 24'($urandom);
      tx_r      = 24'($urandom);
      rx_ready  = ($urandom % 3) == 0;
      clr_flags = ($urandom % 300) == 0;
      tick();
    end
    tx_valid = 1'b0; clr_flags = 1'b0; rx_ready = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
